i_tile_fetch_seq: RTL and testbench

Block-fetch sequencer inside the I-tile, directly upstream of the instruction decoder. It accepts one block-fetch command from the G-tile (base address plus instruction count) and pulses `fetch_new_block` so the decoder clears its auto-LSID/EXIT_ID counters. It then issues in-order word reads to the I-cache and streams the returned 32-bit raw instructions to the decoder over a valid/ready handshake. Flush support lets a misspeculated fetch be aborted cleanly.

---
 rtl/i_tile_fetch_seq.sv | 125 ++++++++++++
 tb/tb_i_tile_fetch_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i_tile_fetch_seq.sv
// i_tile_fetch_seq: block-fetch sequencer that issues in-order I-cache word reads
// and streams the returned raw instructions to the decoder through a credit-checked FIFO.
module i_tile_fetch_seq #(
    parameter int BLOCK_WORDS = 32,
    parameter int ADDR_W = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(BLOCK_WORDS + 1),
    localparam int IW = $clog2(BLOCK_WORDS),
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    input  logic [CW-1:0]     fetch_req_ninstr,
    input  logic              flush,
    output logic              ic_rd_valid,
    output logic [ADDR_W-1:0] ic_rd_addr,
    input  logic              ic_rd_ready,
    input  logic              ic_rsp_valid,
    input  logic [31:0]       ic_rsp_data,
    output logic              fetch_new_block,
    output logic              raw_instr_valid,
    output logic [31:0]       raw_instr,
    output logic [IW-1:0]     raw_instr_idx,
    input  logic              raw_instr_ready,
    output logic              fetch_done
);
    localparam logic [PW:0]   DEPTH = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXN  = CW'(BLOCK_WORDS);

    typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     n, issued, delivered;
    logic [PW:0]       outstanding, drop_cnt, count;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [31:0]       mem_data [FIFO_DEPTH];
    logic [IW-1:0]     mem_idx [FIFO_DEPTH];
    logic              req_fire, rd_fire, push, pop, drop, rsp_used;

    assign req_fire = fetch_req_valid && fetch_req_ready;
    assign rd_fire  = ic_rd_valid && ic_rd_ready;
    assign push     = ic_rsp_valid && state == STREAM;
    assign pop      = raw_instr_valid && raw_instr_ready;
    assign drop     = ic_rsp_valid && drop_cnt != '0;
    assign rsp_used = push || drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            n           <= '0;
            issued      <= '0;
            delivered   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                issued      <= '0;
                delivered   <= '0;
                outstanding <= '0;
                count       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                // reads still in flight come back later and must be swallowed
                drop_cnt    <= drop_cnt + outstanding - (PW + 1)'(rsp_used);
            end else begin
                if (req_fire) begin
                    base      <= {fetch_req_addr[ADDR_W-1:2], 2'b00};
                    n         <= fetch_req_ninstr > MAXN ? MAXN : fetch_req_ninstr;
                    issued    <= '0;
                    delivered <= '0;
                end
                if (rd_fire) issued <= issued + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    delivered <= delivered + 1'b1;
                end
                outstanding <= outstanding + (PW + 1)'(rd_fire) - (PW + 1)'(push);
                count       <= count + (PW + 1)'(push) - (PW + 1)'(pop);
                drop_cnt    <= drop_cnt - (PW + 1)'(drop);
            end
        end
    end

    // returns arrive in order, so the index of a returned word is delivered + buffered
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= ic_rsp_data;
            mem_idx[wr_ptr]  <= IW'(delivered + CW'(count));
        end
    end

    always_comb begin
        state_nxt = flush ? IDLE :
                    state == IDLE   ? (req_fire ? START : IDLE) :
                    state == START  ? (n == '0 ? DONE : STREAM) :
                    state == STREAM ? ((pop && delivered + 1'b1 == n) ? DONE : STREAM) :
                    IDLE;
    end

    // reads are held off during flush so the drop count covers every in-flight read
    always_comb begin
        fetch_req_ready = state == IDLE && drop_cnt == '0 && !flush;
        ic_rd_valid     = state == STREAM && !flush && issued < n && outstanding + count < DEPTH;
        ic_rd_addr      = base + ADDR_W'({issued, 2'b00});
        fetch_new_block = state == START;
        fetch_done      = state == DONE;
        raw_instr_valid = count != '0;
        raw_instr       = raw_instr_valid ? mem_data[rd_ptr] : '0;
        raw_instr_idx   = raw_instr_valid ? mem_idx[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && count == DEPTH));
    end
endmodule

// File: tb/tb_i_tile_fetch_seq.sv
// tb_i_tile_fetch_seq: directed bench with a fixed-latency I-cache model and event monitor.
module tb_i_tile_fetch_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req_valid = 1'b0;
    logic        fetch_req_ready;
    logic [31:0] fetch_req_addr = '0;
    logic [5:0]  fetch_req_ninstr = '0;
    logic        flush = 1'b0;
    logic        ic_rd_valid;
    logic [31:0] ic_rd_addr;
    logic        ic_rd_ready = 1'b1;
    logic        ic_rsp_valid = 1'b0;
    logic [31:0] ic_rsp_data = '0;
    logic        fetch_new_block;
    logic        raw_instr_valid;
    logic [31:0] raw_instr;
    logic [4:0]  raw_instr_idx;
    logic        raw_instr_ready = 1'b1;
    logic        fetch_done;

    i_tile_fetch_seq dut (
        .clk(clk), .rst(rst),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_addr(fetch_req_addr), .fetch_req_ninstr(fetch_req_ninstr),
        .flush(flush),
        .ic_rd_valid(ic_rd_valid), .ic_rd_addr(ic_rd_addr), .ic_rd_ready(ic_rd_ready),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
        .fetch_new_block(fetch_new_block),
        .raw_instr_valid(raw_instr_valid), .raw_instr(raw_instr),
        .raw_instr_idx(raw_instr_idx), .raw_instr_ready(raw_instr_ready),
        .fetch_done(fetch_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          lat = 2;
    int          passed = 0;
    int          total = 0;
    int          failed = 0;
    int          nb_cnt = 0, nb_cyc = 0, done_cnt = 0, done_cyc = 0, rsp_cnt = 0;
    logic [31:0] cq_addr[$];
    int unsigned cq_due[$];
    logic [31:0] rd_q[$];
    int          rd_cyc_q[$];
    logic [4:0]  pop_idx_q[$];
    logic [31:0] pop_dat_q[$];

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // cache model and monitor: mid-cycle, so all values are settled
    always @(negedge clk) begin
        if (rst) begin
            cq_addr.delete();
            cq_due.delete();
            ic_rsp_valid = 1'b0;
        end else begin
            if (ic_rd_valid && ic_rd_ready) begin
                cq_addr.push_back(ic_rd_addr);
                cq_due.push_back(cyc + lat);
                rd_q.push_back(ic_rd_addr);
                rd_cyc_q.push_back(int'(cyc));
            end
            if (cq_due.size() > 0 && cq_due[0] == cyc) begin
                ic_rsp_valid = 1'b1;
                ic_rsp_data  = fdat(cq_addr[0]);
                void'(cq_addr.pop_front());
                void'(cq_due.pop_front());
                rsp_cnt++;
            end else begin
                ic_rsp_valid = 1'b0;
            end
            if (raw_instr_valid && raw_instr_ready) begin
                pop_idx_q.push_back(raw_instr_idx);
                pop_dat_q.push_back(raw_instr);
            end
            if (fetch_new_block) begin
                nb_cnt++;
                nb_cyc = int'(cyc);
            end
            if (fetch_done) begin
                done_cnt++;
                done_cyc = int'(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [5:0] n, output int t);
        fetch_req_valid  = 1'b1;
        fetch_req_addr   = a;
        fetch_req_ninstr = n;
        chk("req_ready_before_cmd", fetch_req_ready, 1);
        t = int'(cyc);
        step();
        fetch_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int k = 0; k < 200 && done_cnt == d0; k++) step();
        chk(tag, done_cnt - d0, 1);
    endtask

    task automatic check_pops(input int p0, input int n, input logic [31:0] a, input string tag);
        int bad = 0;
        chk({tag, "_pop_count"}, pop_idx_q.size() - p0, n);
        for (int i = 0; i < n && p0 + i < pop_idx_q.size(); i++)
            if (pop_idx_q[p0 + i] != 5'(i) || pop_dat_q[p0 + i] != fdat(a + 32'(4 * i))) bad++;
        chk({tag, "_pop_order_errors"}, bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, fetch_req_ready, 1);
        chk({tag, "_rd_valid"}, ic_rd_valid, 0);
        chk({tag, "_new_block"}, fetch_new_block, 0);
        chk({tag, "_raw_valid"}, raw_instr_valid, 0);
        chk({tag, "_done"}, fetch_done, 0);
        chk({tag, "_rd_addr"}, ic_rd_addr, 0);
        chk({tag, "_raw_instr"}, raw_instr, 0);
        chk({tag, "_raw_idx"}, raw_instr_idx, 0);
    endtask

    initial begin
        int t, r0, p0, d0, n0, s0;
        #1;
        check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;
        step();

        // basic fetch, latency 2
        r0 = rd_q.size(); p0 = pop_idx_q.size(); d0 = done_cnt; n0 = nb_cnt;
        do_fetch(32'h1000, 6'd4, t);
        wait_done(d0, "basic_done_pulse");
        chk("basic_new_block_cnt", nb_cnt - n0, 1);
        chk("basic_new_block_cyc", nb_cyc, t + 1);
        chk("basic_first_rd_cyc", rd_q.size() > r0 ? rd_cyc_q[r0] : 0, t + 2);
        chk("basic_rd_count", rd_q.size() - r0, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("basic_rd_addr%0d", i), rd_q[r0 + i], 32'h1000 + 32'(4 * i));
        check_pops(p0, 4, 32'h1000, "basic");
        chk("basic_done_cyc", done_cyc, t + 9);
        chk("basic_ready_after_done", fetch_req_ready, 1);

        // decoder backpressure
        raw_instr_ready = 1'b0;
        r0 = rd_q.size(); p0 = pop_idx_q.size(); d0 = done_cnt;
        do_fetch(32'h2000, 6'd8, t);
        repeat (6) step();
        chk("bp_reads_stalled", rd_q.size() - r0, 4);
        chk("bp_head_valid", raw_instr_valid, 1);
        chk("bp_head_idx", raw_instr_idx, 0);
        chk("bp_head_data", raw_instr, fdat(32'h2000));
        chk("bp_no_pop", pop_idx_q.size() - p0, 0);
        raw_instr_ready = 1'b1;
        wait_done(d0, "bp_done_pulse");
        chk("bp_rd_count", rd_q.size() - r0, 8);
        check_pops(p0, 8, 32'h2000, "bp");

        // zero count
        r0 = rd_q.size(); d0 = done_cnt;
        do_fetch(32'h3000, 6'd0, t);
        wait_done(d0, "zero_done_pulse");
        chk("zero_new_block_cyc", nb_cyc, t + 1);
        chk("zero_done_cyc", done_cyc, t + 2);
        chk("zero_no_reads", rd_q.size() - r0, 0);

        // clamp 40 -> 32
        r0 = rd_q.size(); p0 = pop_idx_q.size(); d0 = done_cnt;
        do_fetch(32'h4000, 6'd40, t);
        wait_done(d0, "clamp_done_pulse");
        chk("clamp_rd_count", rd_q.size() - r0, 32);
        chk("clamp_last_addr", rd_q[$], 32'h407C);
        check_pops(p0, 32, 32'h4000, "clamp");

        // flush with three reads in flight, latency 6
        lat = 6;
        r0 = rd_q.size(); p0 = pop_idx_q.size(); s0 = rsp_cnt;
        do_fetch(32'h5000, 6'd8, t);
        repeat (4) step();
        chk("flush_inflight_reads", rd_q.size() - r0, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_no_read_in_flush", rd_q.size() - r0, 3);
        repeat (4) step();
        chk("flush_ready_while_draining", fetch_req_ready, 0);
        step();
        chk("flush_ready_after_drain", fetch_req_ready, 1);
        chk("flush_rsp_seen", rsp_cnt - s0, 3);
        chk("flush_nothing_delivered", pop_idx_q.size() - p0, 0);
        chk("flush_no_more_reads", rd_q.size() - r0, 3);
        lat = 2;
        p0 = pop_idx_q.size(); d0 = done_cnt;
        do_fetch(32'h6000, 6'd3, t);
        wait_done(d0, "post_flush_done_pulse");
        check_pops(p0, 3, 32'h6000, "post_flush");

        // async reset mid-stream
        do_fetch(32'h7000, 6'd8, t);
        repeat (4) step();
        chk("pre_reset_raw_valid", raw_instr_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        step();
        rst = 1'b0;
        step();
        p0 = pop_idx_q.size(); d0 = done_cnt;
        do_fetch(32'h8000, 6'd2, t);
        wait_done(d0, "post_reset_done_pulse");
        check_pops(p0, 2, 32'h8000, "post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
